// File: rtl/store_issue_unit_if.sv
// Bundle for the store issue unit: the execute-side store port and the
// SRAM-like data-memory write port. The master modport is the store unit.
interface store_issue_unit_if;
  // Execute-stage side
  logic        in_valid;
  logic        in_ready;
  logic        in_flush;
  logic [2:0]  in_store_type;
  logic [31:0] in_addr;
  logic [31:0] in_rt_data;
  logic        st_ade;
  // Data-memory side
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic        busy;

  modport master (
    input  in_valid, in_flush, in_store_type, in_addr, in_rt_data,
    input  data_addr_ok, data_data_ok,
    output in_ready, st_ade,
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output busy
  );

  modport slave (
    output in_valid, in_flush, in_store_type, in_addr, in_rt_data,
    output data_addr_ok, data_data_ok,
    input  in_ready, st_ade,
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  busy
  );
endinterface

// File: rtl/store_issue_unit.sv
// Memory-stage store path: converts SW/SB/SH/SWL/SWR into word-aligned,
// byte-enabled writes, queues up to DEPTH of them and issues them over the
// req/addr_ok/data_ok write port with at most MAX_OUTSTANDING in flight.
// Optional feature macro: STORE_ALIGN_CHECK_EN (misaligned SH/SW raise
// st_ade and are dropped instead of being issued with a[0]/a ignored).
module store_issue_unit #(
  parameter int unsigned DEPTH           = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input logic               clk_i,
  input logic               reset_i,
  store_issue_unit_if.master bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [2:0] {
    StSw  = 3'b000,
    StSb  = 3'b001,
    StSh  = 3'b010,
    StSwl = 3'b011,
    StSwr = 3'b100
  } store_type_e;

  logic [29:0]     addr_q  [DEPTH];
  logic [3:0]      strb_q  [DEPTH];
  logic [31:0]     wdata_q [DEPTH];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [1:0]      outst_q, outst_d;

  store_type_e st_type;
  logic [1:0]  a;
  logic [31:0] rt;
  logic [3:0]  new_strb;
  logic [31:0] new_wdata;
  logic        type_ok, misaligned, ade, enq, pop, done, in_ready, req;

  // Byte-lane placement: mirror of the writeback load merge.
  always_comb begin
    st_type    = store_type_e'(bus.in_store_type);
    a          = bus.in_addr[1:0];
    rt         = bus.in_rt_data;
    type_ok    = 1'b1;
    misaligned = 1'b0;
    new_strb   = 4'b0000;
    new_wdata  = 32'h0;
    case (st_type)
      StSb: begin
        new_strb  = 4'b0001 << a;
        new_wdata = {4{rt[7:0]}};
      end
      StSh: begin
        new_strb   = a[1] ? 4'b1100 : 4'b0011;
        new_wdata  = {2{rt[15:0]}};
        misaligned = a[0];
      end
      StSw: begin
        new_strb   = 4'b1111;
        new_wdata  = rt;
        misaligned = (a != 2'b00);
      end
      StSwl: begin
        unique case (a)
          2'd0: begin new_strb = 4'b0001; new_wdata = {24'b0, rt[31:24]}; end
          2'd1: begin new_strb = 4'b0011; new_wdata = {16'b0, rt[31:16]}; end
          2'd2: begin new_strb = 4'b0111; new_wdata = {8'b0, rt[31:8]};   end
          2'd3: begin new_strb = 4'b1111; new_wdata = rt;                 end
        endcase
      end
      StSwr: begin
        unique case (a)
          2'd0: begin new_strb = 4'b1111; new_wdata = rt;                 end
          2'd1: begin new_strb = 4'b1110; new_wdata = {rt[23:0], 8'b0};   end
          2'd2: begin new_strb = 4'b1100; new_wdata = {rt[15:0], 16'b0};  end
          2'd3: begin new_strb = 4'b1000; new_wdata = {rt[7:0], 24'b0};   end
        endcase
      end
      default: type_ok = 1'b0;
    endcase
  end

`ifdef STORE_ALIGN_CHECK_EN
  // Independent of in_ready so the exception is never delayed by backpressure.
  assign ade = ~reset_i & bus.in_valid & type_ok & misaligned;
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
  assign ade = 1'b0;
`endif

  // Handshake decode; no same-cycle pop bypass into in_ready.
  always_comb begin
    in_ready = ~reset_i & (count_q < CntW'(DEPTH));
    req      = ~reset_i & (count_q != '0) & (outst_q < 2'(MAX_OUTSTANDING));
    enq      = bus.in_valid & in_ready & ~bus.in_flush & type_ok & ~ade;
    pop      = req & bus.data_addr_ok;
    done     = bus.data_data_ok & (outst_q != 2'd0);
  end

  // Pointer, occupancy and in-flight counter next state.
  always_comb begin
    tail_d  = tail_q + PtrW'(enq);
    head_d  = head_q + PtrW'(pop);
    count_d = count_q + CntW'(enq) - CntW'(pop);
    outst_d = outst_q + 2'(pop) - 2'(done);
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      outst_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      outst_q <= outst_d;
    end
  end

  // Queue payload; contents are don't-care until written so no reset.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      addr_q[tail_q]  <= bus.in_addr[31:2];
      strb_q[tail_q]  <= new_strb;
      wdata_q[tail_q] <= new_wdata;
    end
  end

  // Outputs driven from the head entry.
  always_comb begin
    bus.in_ready   = in_ready;
    bus.st_ade     = ade;
    bus.data_req   = req;
    bus.data_wr    = 1'b1;
    bus.data_size  = 2'b10;
    bus.data_addr  = {addr_q[head_q], 2'b00};
    bus.data_wstrb = strb_q[head_q];
    bus.data_wdata = wdata_q[head_q];
    bus.busy       = ~reset_i & ((count_q != '0) | (outst_q != 2'd0));
  end

endmodule

// File: doc/store_issue_unit.md
# store_issue_unit

Memory-stage store path for the 5-stage MIPS pipeline. It accepts store ops (SW/SB/SH/SWL/SWR) from the execute stage and converts each one into a word-aligned, byte-enabled write. It buffers up to `DEPTH` pending stores and issues them to the data memory over the SRAM-like req/addr_ok/data_ok interface. Its byte-lane placement is the mirror of the writeback load merge, so a store followed by a load of the same address round-trips the data.

## Interface
- `DEPTH`, 2: store queue entries, power of two, ≥2.
- `MAX_OUTSTANDING`, 2: issued-but-unacknowledged writes, 1..3.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  store op presented by execute.
- `in_ready`  out  1  unit can enqueue this cycle.
- `in_flush`  in  1  exception/eret this cycle; suppresses the incoming op only.
- `in_store_type`  in  3  000 SW, 001 SB, 010 SH, 011 SWL, 100 SWR; others are ignored (no enqueue).
- `in_addr`  in  32  byte address.
- `in_rt_data`  in  32  rt register value.
- `st_ade`  out  1  address-error pulse for a misaligned SH/SW.
- `data_req`  out  1  write request valid.
- `data_wr`  out  1  constant 1.
- `data_size`  out  2  constant 2'b10.
- `data_addr`  out  32  `{addr[31:2],2'b00}`.
- `data_wstrb`  out  4  byte enables; bit i enables bits [8i+7:8i].
- `data_wdata`  out  32  lane-placed data.
- `data_addr_ok`  in  1  request accepted.
- `data_data_ok`  in  1  write completed, in issue order.
- `busy`  out  1  queue non-empty or outstanding ≠ 0.

## Operation
- **Enqueue:** on `in_valid & in_ready & ~in_flush`, with a valid type and no `st_ade`, the computed {addr, wstrb, wdata} is written at the tail.
- **Lane rules** (a = `in_addr[1:0]`):
  - SB: strb = 1<<a; wdata = {4{rt[7:0]}}.
  - SH: a=0 → 0011, a=2 → 1100; wdata = {2{rt[15:0]}}.
  - SW: 1111; wdata = rt.
  - SWL:
    - a=0 → 0001, {24'b0,rt[31:24]}
    - a=1 → 0011, {16'b0,rt[31:16]}
    - a=2 → 0111, {8'b0,rt[31:8]}
    - a=3 → 1111, rt
  - SWR:
    - a=0 → 1111, rt
    - a=1 → 1110, {rt[23:0],8'b0}
    - a=2 → 1100, {rt[15:0],16'b0}
    - a=3 → 1000, {rt[7:0],24'b0}
- **Issue:** `data_req` = queue non-empty & outstanding < `MAX_OUTSTANDING`. The data/strb/addr outputs are driven from the head entry.
  - On `data_req & data_addr_ok`, the head pops and outstanding increments.
  - Once `data_req` is raised, it and the head fields stay stable until `data_addr_ok`.
- **Completion:** `data_data_ok` decrements outstanding.
  - If issue and completion coincide, outstanding is unchanged.
  - `data_data_ok` with outstanding = 0 is ignored; the counter stays at 0.
- **Flow control:** `in_ready` = count < `DEPTH`, with no same-cycle pop bypass.
  - When enqueue and pop coincide, count is unchanged.
  - Pointers wrap modulo `DEPTH`.
- **Flush:** `in_flush` only blocks the op presented that cycle. Queued and outstanding stores always drain.
- **Reset:** pointers, count and outstanding are cleared.

## Timing
- Reset values: `data_req`=0, `st_ade`=0, `busy`=0. `in_ready`=0 while `reset`=1, then 1 in the first cycle after.
- Latency: enqueue at edge N → `data_req`=1 in cycle N+1, assuming the outstanding limit allows it.
- Throughput: one store per cycle while `data_addr_ok` is held high and completions keep pace.
- `st_ade` is combinational: asserted in the same cycle as the offending `in_valid`, and it does not depend on `in_ready`.
- Reset mid-operation drops all queued and outstanding state. A `data_data_ok` arriving after reset is ignored.

## Configuration
- `STORE_ALIGN_CHECK_EN`:
  - **Defined:** SH with a[0]=1 and SW with a≠0 assert `st_ade` and are not enqueued.
  - **Undefined:** `st_ade` is tied to 0. Misaligned SH uses a[1] only (a[0] ignored); misaligned SW is treated as a=0 (strb 1111).

## Test plan
- Reset, then SB addr 0x1003, rt 0x000000AB → next cycle `data_req`=1, addr 0x1000, strb 1000, wdata 0xABABABAB.
- SWL addr 0x2001, rt 0x11223344 → strb 0011, wdata 0x00001122. SWR addr 0x2001, same rt → strb 1110, wdata 0x22334400.
- `data_addr_ok` held 0, push 3 SW → third op sees `in_ready`=0 after two enqueues; raising `addr_ok` drains them in order with stable fields.
- `MAX_OUTSTANDING`=2, `addr_ok`=1, `data_ok`=0 → `data_req` drops after two issues; one `data_ok` re-enables issue; `busy` falls only after the last `data_ok`.
- SH addr 0x3001 with macro defined → `st_ade`=1 and no enqueue. Without the macro → strb 0011, wdata {2{rt[15:0]}}.
- `in_flush`=1 alongside a valid SW, with one entry queued → the new op is dropped, the queued entry still issues, and `busy` eventually returns to 0.
